// File: rtl/cmd_frame_tx.sv
// Buffered command-frame transmitter: 8N1 bytes sent back-to-back on
// one or two lines, then a line-idle gap the receiver sees as end of frame.
module cmd_frame_tx #(
  parameter int DL    = 26,
  parameter int GAP_T = 3,
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              wr_data,
  input  logic                    wr_en,
  input  logic                    send,
  input  logic [1:0]              tx_sel,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    busy,
  output logic                    done,
  output logic                    stx_a,
  output logic                    stx_b
);

  localparam int BIT_T   = 16 * DL;
  localparam int GAP_LEN = (GAP_T + 1) * 10 * BIT_T;
  localparam int TW      = $clog2(GAP_LEN + 1);
  localparam int PW      = $clog2(DEPTH);
  localparam int CW      = PW + 1;

  localparam logic [TW-1:0] BIT_END = TW'(BIT_T - 1);
  localparam logic [TW-1:0] GAP_END = TW'(GAP_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    GAP
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          tx_q, tx_d;
  logic [1:0]    sel_q, sel_d;
  logic          done_q, done_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;
  logic [7:0]    mem_q [DEPTH];

  logic wr_ok;
  logic send_ok;
  logic line;

  assign full  = (cnt_q == CW'(DEPTH));
  assign count = cnt_q;
  assign busy  = (state_q != IDLE);
  assign done  = done_q;

  // In DATA the shift register LSB is the line; elsewhere tx_q is.
  assign line  = (state_q == DATA) ? sh_q[0] : tx_q;
  assign stx_a = line | ~sel_q[0];
  assign stx_b = line | ~sel_q[1];

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q + TW'(1);
    bit_d   = bit_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    sel_d   = sel_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    wr_ok   = 1'b0;
    send_ok = 1'b0;
    unique case (state_q)
      IDLE: begin
        tmr_d   = '0;
        wr_ok   = wr_en && !full;
        send_ok = send && ((cnt_q != '0) || wr_ok);
        if (wr_ok) wp_d = wp_q + PW'(1);
        cnt_d = cnt_q + CW'(wr_ok) - CW'(send_ok);
        if (send_ok) begin
          state_d = START;
          sel_d   = tx_sel;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (tmr_q == BIT_END) begin
          state_d = DATA;
          tmr_d   = '0;
          sh_d    = mem_q[rp_q];
          rp_d    = rp_q + PW'(1);
          bit_d   = '0;
        end
      end
      DATA: begin
        if (tmr_q == BIT_END) begin
          tmr_d = '0;
          sh_d  = {1'b0, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end
        end
      end
      STOP: begin
        if (tmr_q == BIT_END) begin
          tmr_d = '0;
          if (cnt_q != '0) begin
            state_d = START;
            tx_d    = 1'b0;
            cnt_d   = cnt_q - CW'(1);
          end else begin
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (tmr_q == GAP_END) begin
          state_d = IDLE;
          tmr_d   = '0;
          done_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
      sel_q   <= '0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
      sel_q   <= sel_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_ok) mem_q[wp_q] <= wr_data;
  end

endmodule
